// File: rtl/train_pkg.sv
// Shared types and default geometry for the two-train single-track controller.
// Positions are 10 bits wide; all compare arithmetic is done at 11 bits.
package train_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int TRAIN_LEN = 64;
  localparam int POS_W     = 10;
  localparam int CALC_W    = 11;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_e;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

endpackage

// File: rtl/train_track_controller_section_arbiter.sv
// Owner/priority FSM for the shared single-track section, plus the crossing counter.
// Grants are reported combinationally so the top can let a granted train move on the same tick.
module section_arbiter
  import train_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       clear_a,
  input  logic       clear_b,
  output logic [1:0] owner,
  output logic       grant_a,
  output logic       grant_b,
  output logic [7:0] crossings
);

  owner_e     owner_reg, owner_next;
  prio_e      prio_reg, prio_next;
  logic [7:0] crossings_reg, crossings_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_reg     <= FREE;
      prio_reg      <= PRIO_A;
      crossings_reg <= 8'd0;
    end else if (tick) begin
      owner_reg     <= owner_next;
      prio_reg      <= prio_next;
      crossings_reg <= crossings_next;
    end
  end

  // A release always lands in FREE, so a new grant can only follow on a later tick.
  always_comb begin
    owner_next     = owner_reg;
    prio_next      = prio_reg;
    crossings_next = crossings_reg;
    case (owner_reg)
      FREE: begin
        if (req_a && req_b) begin
          owner_next = (prio_reg == PRIO_A) ? OWN_A : OWN_B;
          prio_next  = (prio_reg == PRIO_A) ? PRIO_B : PRIO_A;
        end else if (req_a) begin
          owner_next = OWN_A;
        end else if (req_b) begin
          owner_next = OWN_B;
        end
      end
      OWN_A: begin
        if (clear_a) begin
          owner_next     = FREE;
          crossings_next = crossings_reg + 8'd1;
        end
      end
      OWN_B: begin
        if (clear_b) begin
          owner_next     = FREE;
          crossings_next = crossings_reg + 8'd1;
        end
      end
      default: owner_next = FREE;
    endcase
  end

  always_comb begin
    owner     = owner_reg;
    crossings = crossings_reg;
    grant_a   = tick && (owner_reg == FREE) && (owner_next == OWN_A);
    grant_b   = tick && (owner_reg == FREE) && (owner_next == OWN_B);
  end

endmodule

// File: rtl/train_track_controller.sv
// Per-frame motion of two opposing trains sharing one single-track section,
// with request/clear detection, arbitration and a sticky collision flag.
module train_track_controller
  import train_pkg::*;
#(
  parameter int H_ACTIVE     = train_pkg::H_ACTIVE,
  parameter int TRAIN_LEN    = train_pkg::TRAIN_LEN,
  parameter int SPEED        = 2,
  parameter int SHARED_START = 256,
  parameter int SHARED_END   = 383
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       run,
  output logic [9:0] train_a_x,
  output logic [9:0] train_b_x,
  output logic       signal_a,
  output logic       signal_b,
  output logic [1:0] owner,
  output logic [7:0] crossings,
  output logic       collision
);

  localparam logic [CALC_W-1:0] HACT = CALC_W'(H_ACTIVE);
  localparam logic [CALC_W-1:0] LEN  = CALC_W'(TRAIN_LEN);
  localparam logic [CALC_W-1:0] SPD  = CALC_W'(SPEED);
  localparam logic [CALC_W-1:0] S_ST = CALC_W'(SHARED_START);
  localparam logic [CALC_W-1:0] S_EN = CALC_W'(SHARED_END);

  logic [POS_W-1:0]  x_a_reg, x_b_reg;
  logic              collision_reg;
  logic [CALC_W-1:0] a_ext, b_ext, head_a, a_step, b_step, a_next, b_next;
  logic              tick, req_a, req_b, clear_a, clear_b, grant_a, grant_b;
  logic              stall_a, stall_b, in_a, in_b;

  assign tick = frame_tick && run;

  always_comb begin
    a_ext   = {1'b0, x_a_reg};
    b_ext   = {1'b0, x_b_reg};
    head_a  = a_ext + LEN - 11'd1;
    req_a   = (head_a < S_ST) && (head_a + SPD >= S_ST);
    clear_a = a_ext > S_EN;
    req_b   = (b_ext > S_EN) && (b_ext - SPD <= S_EN);
    clear_b = (b_ext + LEN - 11'd1) < S_ST;
  end

  section_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .req_a     (req_a),
    .req_b     (req_b),
    .clear_a   (clear_a),
    .clear_b   (clear_b),
    .owner     (owner),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .crossings (crossings)
  );

  // A train waiting at the section boundary holds until it is granted or already owns it.
  always_comb begin
    stall_a = req_a && !grant_a && (owner != OWN_A);
    stall_b = req_b && !grant_b && (owner != OWN_B);
    a_step  = (a_ext + LEN + SPD > HACT) ? 11'd0 : a_ext + SPD;
    b_step  = (b_ext < SPD) ? HACT - LEN : b_ext - SPD;
    a_next  = stall_a ? a_ext : a_step;
    b_next  = stall_b ? b_ext : b_step;
    in_a    = (a_next <= S_EN) && (a_next + LEN - 11'd1 >= S_ST);
    in_b    = (b_next <= S_EN) && (b_next + LEN - 11'd1 >= S_ST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_a_reg       <= '0;
      x_b_reg       <= POS_W'(H_ACTIVE - TRAIN_LEN);
      collision_reg <= 1'b0;
    end else if (tick) begin
      x_a_reg       <= a_next[POS_W-1:0];
      x_b_reg       <= b_next[POS_W-1:0];
      collision_reg <= collision_reg | (in_a & in_b);
    end
  end

  assign train_a_x = x_a_reg;
  assign train_b_x = x_b_reg;
  assign signal_a  = (owner != OWN_B);
  assign signal_b  = (owner != OWN_A);
  assign collision = collision_reg;

endmodule

// File: tb/tb_train_track_controller.sv
// Directed bench for train_track_controller: hand-derived positions, ownership,
// wrap-around, run gating, reset mid-crossing and a long free run.
module tb_train_track_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       run = 1'b1;
  logic [9:0] train_a_x, train_b_x;
  logic       signal_a, signal_b, collision;
  logic [1:0] owner;
  logic [7:0] crossings;

  int compared   = 0;
  int mismatched = 0;

  train_track_controller dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .run        (run),
    .train_a_x  (train_a_x),
    .train_b_x  (train_b_x),
    .signal_a   (signal_a),
    .signal_b   (signal_b),
    .owner      (owner),
    .crossings  (crossings),
    .collision  (collision)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One frame tick: pulse high for one cycle; outputs sampled on the next falling edge.
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_xa"}, train_a_x, 0);
    chk({tag, "_xb"}, train_b_x, 576);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_sig_a"}, signal_a, 1);
    chk({tag, "_sig_b"}, signal_b, 1);
    chk({tag, "_cross"}, crossings, 0);
    chk({tag, "_coll"}, collision, 0);
  endtask

  int last_grant;
  int prev_owner;
  int prev_cross;
  int grants;

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("reset");

    // Ticks 1..96: both trains run freely toward the section.
    do_ticks(96);
    chk("t96_xa", train_a_x, 192);
    chk("t96_xb", train_b_x, 384);
    chk("t96_owner", owner, 0);
    chk("t96_sig_a", signal_a, 1);
    chk("t96_sig_b", signal_b, 1);

    // Tick 97: simultaneous requests, priority starts at A.
    do_ticks(1);
    chk("t97_owner", owner, 1);
    chk("t97_xa", train_a_x, 194);
    chk("t97_xb_hold", train_b_x, 384);
    chk("t97_sig_a", signal_a, 1);
    chk("t97_sig_b", signal_b, 0);

    // Ticks with run low are lost entirely.
    run = 1'b0;
    do_ticks(50);
    chk("norun_xa", train_a_x, 194);
    chk("norun_xb", train_b_x, 384);
    chk("norun_owner", owner, 1);
    chk("norun_cross", crossings, 0);
    run = 1'b1;

    do_ticks(95);
    chk("t192_xa", train_a_x, 384);
    chk("t192_owner", owner, 1);
    chk("t192_xb", train_b_x, 384);

    do_ticks(1);
    chk("t193_owner", owner, 0);
    chk("t193_cross", crossings, 1);
    chk("t193_xa", train_a_x, 386);
    chk("t193_xb", train_b_x, 384);

    do_ticks(1);
    chk("t194_owner", owner, 2);
    chk("t194_xb", train_b_x, 382);
    chk("t194_sig_a", signal_a, 0);
    chk("t194_sig_b", signal_b, 1);

    // Train A wrap: 574 -> 576 -> 0.
    do_ticks(93);
    chk("t287_xa", train_a_x, 574);
    do_ticks(1);
    chk("t288_xa", train_a_x, 576);
    do_ticks(1);
    chk("t289_xa_wrap", train_a_x, 0);
    chk("t289_xb", train_b_x, 192);
    chk("t289_owner", owner, 2);

    do_ticks(1);
    chk("t290_owner", owner, 0);
    chk("t290_cross", crossings, 2);
    chk("t290_xb", train_b_x, 190);

    // Train B wrap: 0 -> 576; A requests alone and is granted.
    do_ticks(95);
    chk("t385_xb", train_b_x, 0);
    chk("t385_xa", train_a_x, 192);
    do_ticks(1);
    chk("t386_xb_wrap", train_b_x, 576);
    chk("t386_owner", owner, 1);
    chk("t386_xa", train_a_x, 194);
    chk("t386_coll", collision, 0);

    // Reset with a simultaneous tick while A owns the section.
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b0;
    chk_reset_state("midreset");

    // Long free run: grants must alternate and each release bumps crossings.
    last_grant = -1;
    prev_owner = owner;
    prev_cross = crossings;
    grants = 0;
    for (int t = 0; t < 10000; t++) begin
      do_ticks(1);
      if (prev_owner == 0 && owner != 0) begin
        if (last_grant >= 0)
          chk("free_alternate", owner, (last_grant == 1) ? 2 : 1);
        last_grant = owner;
        grants++;
      end
      if (prev_owner != 0 && owner == 0)
        chk("free_cross_inc", crossings, (prev_cross + 1) % 256);
      prev_owner = owner;
      prev_cross = crossings;
    end
    chk("free_collision", collision, 0);
    chk("free_progress", (grants >= 40) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
